fetch_queue: RTL

Instruction buffer between the fetch stage and decode/dispatch. It accepts one fetched instruction and its PC per cycle over a valid/ready handshake and holds them in a circular FIFO. It presents them in program order to decode and drops all contents on a pipeline flush (branch mispredict or exception redirect). Its `almost_full` output is the stall signal that fetch uses to hold its PC.

---
 rtl/fetch_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction buffer between fetch and decode. Circular FIFO of
//               {instr, pc} entries with valid/ready on both sides, flush,
//               and an almost_full stall indication for the fetch PC.
//               Optional same-cycle bypass when empty: FETCHQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int PC_WIDTH     = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     in_ready,
  output logic                     almost_full,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [PC_WIDTH-1:0]      out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      wptr;
  logic [CNT_W-1:0]      count_r;

  logic stored_valid;
  logic bypass_hit;
  logic push;
  logic pop;

  assign stored_valid = (count_r != '0);
  assign in_ready     = (count_r != C_FULL);
  assign almost_full  = (count_r >= C_AFULL);
  assign count        = count_r;

`ifdef FETCHQ_BYPASS_EN
  // Empty queue forwards the incoming instruction straight to decode
  always_comb begin
    bypass_hit = !stored_valid && in_valid && !flush && !reset;
    out_valid  = stored_valid || bypass_hit;
    out_instr  = bypass_hit ? in_instr : instr_mem[rptr];
    out_pc     = bypass_hit ? in_pc    : pc_mem[rptr];
    // A bypassed instruction that decode takes now never enters storage
    push       = in_valid && in_ready && !(bypass_hit && out_ready);
    pop        = stored_valid && out_ready;
  end
`else
  // Outputs come only from registered state; head entry is at rptr
  always_comb begin
    bypass_hit = 1'b0;
    out_valid  = stored_valid;
    out_instr  = instr_mem[rptr];
    out_pc     = pc_mem[rptr];
    push       = in_valid && in_ready;
    pop        = stored_valid && out_ready;
  end
`endif

  // Pointer, occupancy and storage update; reset > flush > push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr    <= '0;
      wptr    <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      // Contents are left in place; only the bookkeeping is cleared
      rptr    <= '0;
      wptr    <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        instr_mem[wptr] <= in_instr;
        pc_mem[wptr]    <= in_pc;
        wptr            <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop && !push) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
